// File: rtl/led_ring_decoder.sv
// Receive side of a 4-position one-hot LED ring: decodes the position, locks onto
// forward rotation, counts completed laps and flags sequence violations once locked.
module led_ring_decoder #(
  parameter int unsigned LAP_W      = 8,
  parameter int unsigned LOCK_STEPS = 2
) (
  input  logic             clk,
  input  logic             resetBtn,
  input  logic             sample_en,
  input  logic [3:0]       led_in,
  output logic [1:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             lap_tick,
  output logic [LAP_W-1:0] lap_count
);

  typedef enum logic [1:0] {StHunt, StLocking, StLocked} state_e;

  localparam logic [2:0] LockSteps = 3'(LOCK_STEPS);

  state_e           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [2:0]       step_q, step_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             seq_err_q, seq_err_d;
  logic             lap_tick_q, lap_tick_d;
  logic [LAP_W-1:0] lap_q, lap_d;

  logic       onehot;
  logic [1:0] dec;
  logic [1:0] prev_inc;

  always_comb begin
    onehot = 1'b1;
    dec    = 2'd0;
    case (led_in)
      4'b0001: dec = 2'd0;
      4'b0010: dec = 2'd1;
      4'b0100: dec = 2'd2;
      4'b1000: dec = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  // 2-bit add wraps 3 -> 0, which is exactly the ring's forward step
  assign prev_inc = prev_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    step_d     = step_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    seq_err_d  = 1'b0;
    lap_tick_d = 1'b0;
    lap_d      = lap_q;

    if (sample_en) begin
      valid_d = onehot;
      if (onehot) begin
        idx_d = dec;
      end

      case (state_q)
        StHunt: begin
          if (onehot) begin
            prev_d  = dec;
            step_d  = 3'd0;
            state_d = StLocking;
          end
        end
        StLocking: begin
          if (!onehot) begin
            state_d = StHunt;
          end else if (dec == prev_inc) begin
            prev_d = dec;
            step_d = step_q + 3'd1;
            if (step_q + 3'd1 == LockSteps) begin
              state_d = StLocked;
            end
          end else if (dec != prev_q) begin
            prev_d = dec;
            step_d = 3'd0;
          end
        end
        StLocked: begin
          if (onehot && dec == prev_inc) begin
            prev_d = dec;
            if (prev_q == 2'd3) begin
              lap_tick_d = 1'b1;
              lap_d      = lap_q + LAP_W'(1);
            end
          end else if (!(onehot && dec == prev_q)) begin
            // skip, backward step or corrupt pattern
            seq_err_d = 1'b1;
            state_d   = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetBtn) begin
    if (resetBtn) begin
      state_q    <= StHunt;
      prev_q     <= 2'd0;
      step_q     <= 3'd0;
      idx_q      <= 2'd0;
      valid_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      lap_tick_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      seq_err_q  <= seq_err_d;
      lap_tick_q <= lap_tick_d;
      lap_q      <= lap_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = valid_q;
  assign locked    = (state_q == StLocked);
  assign seq_err   = seq_err_q;
  assign lap_tick  = lap_tick_q;
  assign lap_count = lap_q;

endmodule

// File: tb/tb_led_ring_decoder.sv
// Bench for led_ring_decoder: directed vector table, hand-written reset/lap-wrap
// sequences, and random stimulus against a behavioural ring model.
module tb_led_ring_decoder;

  logic       clk = 1'b0;
  logic       resetBtn;
  logic       sample_en;
  logic [3:0] led_in;
  logic [1:0] idx, idx2;
  logic       idx_valid, idx_valid2;
  logic       locked, locked2;
  logic       seq_err, seq_err2;
  logic       lap_tick, lap_tick2;
  logic [7:0] lap_count;
  logic [1:0] lap_count2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_ring_decoder #(.LAP_W(8), .LOCK_STEPS(2)) u_dut (
    .clk       (clk),
    .resetBtn  (resetBtn),
    .sample_en (sample_en),
    .led_in    (led_in),
    .idx       (idx),
    .idx_valid (idx_valid),
    .locked    (locked),
    .seq_err   (seq_err),
    .lap_tick  (lap_tick),
    .lap_count (lap_count)
  );

  led_ring_decoder #(.LAP_W(2), .LOCK_STEPS(2)) u_dut2 (
    .clk       (clk),
    .resetBtn  (resetBtn),
    .sample_en (sample_en),
    .led_in    (led_in),
    .idx       (idx2),
    .idx_valid (idx_valid2),
    .locked    (locked2),
    .seq_err   (seq_err2),
    .lap_tick  (lap_tick2),
    .lap_count (lap_count2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_outs(input string tag, input int e_idx, input int e_valid,
                            input int e_locked, input int e_seq, input int e_tick,
                            input int e_laps);
    check({tag, " idx"},       int'(idx),       e_idx);
    check({tag, " idx_valid"}, int'(idx_valid), e_valid);
    check({tag, " locked"},    int'(locked),    e_locked);
    check({tag, " seq_err"},   int'(seq_err),   e_seq);
    check({tag, " lap_tick"},  int'(lap_tick),  e_tick);
    check({tag, " lap_count"}, int'(lap_count), e_laps % 256);
    check({tag, " lap_count2"}, int'(lap_count2), e_laps % 4);
    check({tag, " no_dual_pulse"}, int'(seq_err & lap_tick), 0);
  endtask

  // Behavioural model: mode 0=hunt 1=locking 2=locked
  int m_mode, m_prev, m_steps, m_idx, m_valid, m_seq, m_tick, m_laps;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_steps = 0; m_idx = 0; m_valid = 0;
    m_seq = 0; m_tick = 0; m_laps = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] led);
    int pos;
    bit ok;
    m_seq  = 0;
    m_tick = 0;
    if (!en) return;
    ok  = ($countones(led) == 1);
    pos = 0;
    for (int b = 0; b < 4; b++) if (led[b]) pos = b;
    m_valid = ok;
    if (ok) m_idx = pos;
    case (m_mode)
      0: if (ok) begin m_prev = pos; m_steps = 0; m_mode = 1; end
      1: begin
        if (!ok) m_mode = 0;
        else if (pos == (m_prev + 1) % 4) begin
          m_steps++;
          m_prev = pos;
          if (m_steps == 2) m_mode = 2;
        end else if (pos != m_prev) begin
          m_prev = pos; m_steps = 0;
        end
      end
      default: begin
        if (ok && pos == (m_prev + 1) % 4) begin
          if (m_prev == 3) begin m_tick = 1; m_laps++; end
          m_prev = pos;
        end else if (!(ok && pos == m_prev)) begin
          m_seq = 1; m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic apply(input bit en, input logic [3:0] led);
    sample_en = en;
    led_in    = led;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetBtn  = 1'b1;
    sample_en = 1'b0;
    led_in    = 4'b0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetBtn = 1'b0;
  endtask

  typedef struct {
    bit         en;
    logic [3:0] led;
    int         e_idx, e_valid, e_locked, e_seq, e_tick, e_laps;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit en, input logic [3:0] led, input int i, input int v,
                     input int l, input int s, input int t, input int n);
    vec_t x;
    x.en = en; x.led = led; x.e_idx = i; x.e_valid = v; x.e_locked = l;
    x.e_seq = s; x.e_tick = t; x.e_laps = n;
    vecs.push_back(x);
  endtask

  initial begin
    logic [3:0] led;
    int stim;
    bit en;
    int r;

    resetBtn  = 1'b1;
    sample_en = 1'b0;
    led_in    = 4'b0000;
    #12;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetBtn = 1'b0;

    //  en  led      idx v  L  s  t  laps
    add(1, 4'b0001, 0, 1, 0, 0, 0, 0);
    add(1, 4'b0010, 1, 1, 0, 0, 0, 0);
    add(1, 4'b0100, 2, 1, 1, 0, 0, 0);  // locked after third sample
    add(1, 4'b1000, 3, 1, 1, 0, 0, 0);
    add(1, 4'b0001, 0, 1, 1, 0, 1, 1);  // lap tick on 3->0
    add(0, 4'b0001, 0, 1, 1, 0, 0, 1);  // tick gone while idle
    add(1, 4'b0010, 1, 1, 1, 0, 0, 1);
    add(1, 4'b1000, 3, 1, 0, 1, 0, 1);  // skip -> seq_err, hunt
    add(1, 4'b0001, 0, 1, 0, 0, 0, 1);
    add(1, 4'b0010, 1, 1, 0, 0, 0, 1);
    add(1, 4'b0100, 2, 1, 1, 0, 0, 1);
    add(1, 4'b0110, 2, 0, 0, 1, 0, 1);  // corrupt -> idx held, seq_err
    add(1, 4'b0000, 2, 0, 0, 0, 0, 1);  // hunt, no pulse
    add(1, 4'b0100, 2, 1, 0, 0, 0, 1);
    add(1, 4'b1000, 3, 1, 0, 0, 0, 1);
    add(1, 4'b0001, 0, 1, 1, 0, 0, 1);  // lock-completing 3->0: no tick
    add(1, 4'b0001, 0, 1, 1, 0, 0, 1);  // held position
    add(1, 4'b0010, 1, 1, 1, 0, 0, 1);
    add(1, 4'b0100, 2, 1, 1, 0, 0, 1);
    add(1, 4'b0100, 2, 1, 1, 0, 0, 1);
    add(0, 4'b1111, 2, 1, 1, 0, 0, 1);  // idle: garbage ignored
    add(1, 4'b0100, 2, 1, 1, 0, 0, 1);
    add(0, 4'b0000, 2, 1, 1, 0, 0, 1);
    add(1, 4'b0100, 2, 1, 1, 0, 0, 1);
    add(1, 4'b0010, 1, 1, 0, 1, 0, 1);  // backward step
    add(0, 4'b0010, 1, 1, 0, 0, 0, 1);  // pulse is single-cycle

    foreach (vecs[k]) begin
      apply(vecs[k].en, vecs[k].led);
      check_outs($sformatf("vec%0d", k), vecs[k].e_idx, vecs[k].e_valid,
                 vecs[k].e_locked, vecs[k].e_seq, vecs[k].e_tick, vecs[k].e_laps);
    end

    // Async reset between edges clears everything before the next edge
    apply(1, 4'b0001);
    apply(1, 4'b0010);
    #2;
    resetBtn = 1'b1;
    #1;
    check_outs("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetBtn = 1'b0;

    // First edge after release is processed from hunt; lock needs full sequence
    apply(1, 4'b0100);
    check_outs("post_reset0", 2, 1, 0, 0, 0, 0);
    apply(1, 4'b1000);
    check_outs("post_reset1", 3, 1, 0, 0, 0, 0);
    apply(1, 4'b0001);
    check_outs("post_reset2", 0, 1, 1, 0, 0, 0);

    // Four locked laps: narrow counter wraps 1,2,3,0
    for (int lap = 1; lap <= 4; lap++) begin
      apply(1, 4'b0010);
      apply(1, 4'b0100);
      apply(1, 4'b1000);
      apply(1, 4'b0001);
      check($sformatf("wrap lap%0d count2", lap), int'(lap_count2), lap % 4);
      check($sformatf("wrap lap%0d tick2", lap), int'(lap_tick2), 1);
      check($sformatf("wrap lap%0d count", lap), int'(lap_count), lap);
    end

    // Random phase against the behavioural model
    do_reset();
    model_reset();
    stim = 0;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 99);
      if (r < 60) stim = (stim + 1) % 4;
      else if (r < 75) stim = stim;
      else if (r < 85) stim = (stim + 2) % 4;
      else if (r < 92) stim = (stim + 3) % 4;
      led = 4'b0001 << stim;
      if (r >= 92) led = 4'($urandom_range(0, 15));
      apply(en, led);
      model_step(en, led);
      check_outs($sformatf("rnd%0d", c), m_idx, m_valid, int'(m_mode == 2), m_seq,
                 m_tick, m_laps);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_ring_decoder.md
LED_RING_DECODER -- requirements
Module: led_ring_decoder

Interface
- REQ-001: Parameter LAP_W, default 8, width of the lap counter.
- REQ-002: Parameter LOCK_STEPS, default 2, number of consecutive correct forward steps required to lock (legal range 1..7).
- REQ-003: The block SHALL use one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock) and resetBtn (input, 1, async active-high reset).
- REQ-004: sample_en  input  1  qualifies led_in; the block acts only in cycles where it is high.
- REQ-005: led_in  input  4  observed ring-LED pattern; bit n high means position n.
- REQ-006: idx  output  2  last decoded position (registered).
- REQ-007: idx_valid  output  1  high when the last sampled led_in was exactly one-hot.
- REQ-008: locked  output  1  high while in state LOCKED.
- REQ-009: seq_err  output  1  one-cycle pulse on a sequence violation while LOCKED.
- REQ-010: lap_tick  output  1  one-cycle pulse on each locked 3->0 wrap.
- REQ-011: lap_count  output  LAP_W  number of completed locked laps, modulo 2^LAP_W.

Function
- REQ-012: The block SHALL be the receive side of the 4-position one-hot LED ring: positions advance 0->1->2->3->0, and each position is encoded as exactly one high bit at the matching index of led_in.
- REQ-013: The decode SHALL be one-hot valid iff exactly one bit of led_in is set; the decoded idx is that bit's index.
- REQ-014: All outputs SHALL be registered, updating on the clk edge where sample_en=1, so latency from sample to output is 1 cycle.
- REQ-015: With sample_en=0, state, idx, idx_valid, lap_count and the stored previous position SHALL hold, and seq_err and lap_tick SHALL be 0.
- REQ-016: On a valid sample, idx SHALL be loaded with the decoded index. On an invalid sample (zero bits or more than one bit set), idx SHALL hold and idx_valid SHALL go to 0.
- REQ-017: FSM states: HUNT, LOCKING, LOCKED. The block SHALL keep prev (2 bits) and a step counter (3 bits).
- REQ-018: HUNT: a valid sample SHALL load prev=idx, clear the step counter and move to LOCKING. An invalid sample SHALL stay in HUNT.
- REQ-019: LOCKING, on a valid sample equal to prev+1 mod 4: the block SHALL increment the step counter and set prev=idx. When the counter reaches LOCK_STEPS, it SHALL move to LOCKED.
- REQ-020: LOCKING, on a valid sample equal to prev: no change (a held position is legal).
- REQ-021: LOCKING, on any other valid sample: the block SHALL set prev=idx, clear the counter and stay in LOCKING. An invalid sample SHALL move to HUNT. No seq_err is raised in LOCKING.
- REQ-022: LOCKED, on a valid sample equal to prev+1 mod 4: the block SHALL set prev=idx. If prev was 3, it SHALL also pulse lap_tick and increment lap_count, wrapping 2^LAP_W-1 -> 0.
- REQ-023: LOCKED, on a valid sample equal to prev: the block SHALL hold with no pulse.
- REQ-024: LOCKED, on a skip, a backward step or an invalid sample: the block SHALL pulse seq_err, move to HUNT, and have locked=0 on the same edge. lap_count SHALL be retained.
- REQ-025: The lock-completing step SHALL not generate lap_tick, even when it is a 3->0 step. Only steps taken while already LOCKED count as laps.
- REQ-026: seq_err and lap_tick SHALL never both be high in the same cycle.

Reset
- REQ-027: Asserting resetBtn SHALL immediately, without waiting for clk, set state=HUNT, prev=0, step counter=0, idx=0, idx_valid=0, locked=0, seq_err=0, lap_tick=0 and lap_count=0.
- REQ-028: Reset asserted mid-lap SHALL discard progress. After release, the block SHALL require a fresh HUNT->LOCKING->LOCKED sequence.
- REQ-029: The first sample_en edge after reset release SHALL be processed normally from HUNT.

Verification
- REQ-030: Reset, then sample 0001,0010,0100 with sample_en=1 -> locked=1 after the third sample, idx=2, lap_count=0.
- REQ-031: While locked at idx=2, sample 1000,0001 -> lap_tick pulses once on the 0001 edge, lap_count=1, seq_err=0.
- REQ-032: While locked at idx=1, sample 1000 (skip) -> seq_err pulses once, locked=0, state HUNT, lap_count unchanged.
- REQ-033: While locked, sample 0110 -> idx_valid=0, idx held, seq_err=1 for one cycle, HUNT. Then sample 0000 -> stays HUNT, no pulse.
- REQ-034: While locked, sample 0100,0100,0100 with sample_en toggling 1/0 -> no pulses, locked stays 1, outputs hold in the sample_en=0 cycles.
- REQ-035: With LAP_W=2, run 4 locked laps -> lap_count goes 1,2,3,0. Asserting resetBtn between clock edges -> all outputs 0 before the next edge.
